qed_inst_stream_constraint: RTL and testbench
=============================================

// Module: qed_inst_stream_constraint
// PURPOSE
//  Parametrised, stateful successor to the SQED instruction constraint. Decodes the fetched instruction
//  stream and qualifies it with a phase FSM: register-init warm-up, free run, drain. Also bounds NOP runs,
//  gates MUL/memory classes by parameter, and latches the first violation. `allowed` feeds the formal
//  assume (inside `ifdef FORMAL`) and is usable as a simulation checker.
// PARAMETERS
//  REG_LIMIT      16  registers rs1/rs2/rd must be < REG_LIMIT (power of 2, 2..32); upper half reserved for QED dups
//  ENABLE_MUL     1   1: MUL/MULH/MULHSU/MULHU legal; 0: illegal
//  ENABLE_MEM     1   1: LW/SW legal in RUN; 0: never legal
//  MEM_BASE_REG   0   required rs1 for LW/SW
//  MAX_NOP_RUN    4   max consecutive accepted NOPs (1..255)
//  WARMUP_INSTS   8   accepted non-NOP instrs before RUN (0: enter RUN straight from reset)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  instruction    in   32  candidate instruction word
//  inst_valid     in   1   instruction is issued this cycle
//  drain_req      in   1   level; request to enter DRAIN
//  allowed        out  1   instruction is legal in current state (combinational)
//  inst_class     out  3   0 NONE,1 I,2 R,3 LW,4 SW,5 NOP (combinational)
//  phase          out  2   0 WARMUP,1 RUN,2 DRAIN (registered)
//  nop_run        out  8   current consecutive NOP count (registered)
//  violation      out  1   sticky: a valid, disallowed instruction was seen
//  viol_instr     out  32  first violating instruction word
// BEHAVIOUR
//  Reset (async, rst_n=0): phase=WARMUP (RUN if WARMUP_INSTS==0), nop_run=0, warm_cnt=0,
//   violation=0, viol_instr=0. Mid-operation reset discards all state immediately.
//  Decode (comb): I = ADDI,SLTI,SLTIU,XORI,ORI,ANDI, SLLI/SRLI (funct7=0), SRAI (funct7=0100000);
//   R = ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND + MUL group (funct7=0000001, funct3 000..011) if ENABLE_MUL;
//   LW op 0000011 f3 010; SW op 0100011 f3 010; NOP op 1111111. Anything else -> NONE.
//  Format (enforced for every class): used regs < REG_LIMIT; LW/SW also need instr[31:30]==00 and
//   rs1==MEM_BASE_REG. Failing format -> class NONE.
//  allowed = class!=NONE and phase rule and NOP rule:
//   WARMUP: I, R, NOP only; RUN: I, R, NOP, LW/SW if ENABLE_MEM; DRAIN: NOP only.
//   NOP allowed only while nop_run < MAX_NOP_RUN.
//  Updates occur only on clock edges with inst_valid=1 (state holds otherwise), except DRAIN entry:
//   accepted NOP: nop_run+1 (saturating at 255); any other accepted instr: nop_run=0.
//   WARMUP: each allowed non-NOP increments warm_cnt; when it reaches WARMUP_INSTS -> RUN next cycle.
//   drain_req=1 in WARMUP or RUN -> DRAIN on the next edge regardless of inst_valid; takes priority over
//    warm-up completion. DRAIN is terminal until reset.
//  Violation: inst_valid && !allowed -> violation=1 next edge; viol_instr captured only when violation
//   was 0 (first one wins); a violation does not change phase or counters.
//  inst_valid=0: allowed/inst_class still driven from instruction; no state change.
//  FORMAL: assume property (@(posedge clk) disable iff(!rst_n) inst_valid |-> allowed).
// STRUCTURE
//  Package qed_inst_pkg: opcode/funct3/funct7 localparams, class codes, phase codes.
//  Sub-module qed_inst_decode: combinational decode + format check -> inst_class (shared with other QED blocks).
//  Top: phase FSM, warm-up counter, NOP-run counter, violation latch.
// TESTING
//  1 Reset, 8x valid ADDI x1,x2,5 (0x00510093) -> phase 0 through 8th, phase=1 the cycle after; allowed=1.
//  2 In WARMUP, valid LW x1,0(x0) (0x00002083) -> allowed=0, violation=1, viol_instr=0x00002083, phase stays 0.
//  3 In RUN, 4x NOP 0x0000007F then 5th NOP -> allowed=0 on 5th; SW 0x00102023 -> allowed=1, nop_run=0.
//  4 ADD x20,x1,x2 (0x00208A33) with REG_LIMIT=16 -> class 0, allowed=0; same with REG_LIMIT=32 -> allowed=1.
//  5 ENABLE_MUL=0: MUL x1,x2,x3 (0x023100B3) -> allowed=0; ENABLE_MUL=1 -> class 2, allowed=1.
//  6 drain_req=1 in RUN with inst_valid=0 -> phase=2 next edge; ADDI -> allowed=0; rst_n low mid-run -> phase=0, violation=0 at once.

Source files
------------

// File: rtl/qed_inst_pkg.sv
// Shared encodings for the QED instruction-stream constraint blocks:
// RV32 opcode/funct fields, instruction class codes and phase codes.
package qed_inst_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_NOP    = 7'b1111111;

    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_WORD   = 3'b010;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_I    = 3'd1,
        CLS_R    = 3'd2,
        CLS_LW   = 3'd3,
        CLS_SW   = 3'd4,
        CLS_NOP  = 3'd5
    } inst_class_e;

    typedef enum logic [1:0] {
        PH_WARMUP = 2'd0,
        PH_RUN    = 2'd1,
        PH_DRAIN  = 2'd2
    } phase_e;

    function automatic logic is_alu_class(input logic [2:0] cls);
        return (cls == CLS_I) || (cls == CLS_R);
    endfunction

    function automatic logic is_mem_class(input logic [2:0] cls);
        return (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/qed_inst_decode.sv
// Combinational decode of one instruction word into a QED class; any word
// that fails the register/addressing format check collapses to CLS_NONE.
module qed_inst_decode
    import qed_inst_pkg::*;
#(
    parameter int REG_LIMIT    = 16,
    parameter int ENABLE_MUL   = 1,
    parameter int MEM_BASE_REG = 0
) (
    input  logic [31:0] instruction,
    output logic [2:0]  inst_class
);

    localparam logic [5:0] REG_LIM  = 6'(REG_LIMIT);
    localparam logic [4:0] MEM_BASE = 5'(MEM_BASE_REG);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    inst_class_e w_raw_class;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_is_mem;
    logic        w_fmt_ok;

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_funct3 = instruction[14:12];
    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];
    assign w_funct7 = instruction[31:25];

    function automatic logic reg_ok(input logic [4:0] r);
        return {1'b0, r} < REG_LIM;
    endfunction

    // Opcode/funct decode, then register-range and memory addressing checks.
    always_comb begin
        w_raw_class = CLS_NONE;
        w_use_rd    = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_is_mem    = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                case (w_funct3)
                    F3_SLL:  w_raw_class = (w_funct7 == F7_BASE) ? CLS_I : CLS_NONE;
                    F3_SR:   w_raw_class = ((w_funct7 == F7_BASE) || (w_funct7 == F7_ALT)) ? CLS_I : CLS_NONE;
                    default: w_raw_class = CLS_I;
                endcase
            end
            OP_REG: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                case (w_funct7)
                    F7_BASE:   w_raw_class = CLS_R;
                    F7_ALT:    w_raw_class = ((w_funct3 == F3_ADDSUB) || (w_funct3 == F3_SR)) ? CLS_R : CLS_NONE;
                    F7_MULDIV: w_raw_class = ((ENABLE_MUL != 0) && !w_funct3[2]) ? CLS_R : CLS_NONE;
                    default:   w_raw_class = CLS_NONE;
                endcase
            end
            OP_LOAD: begin
                w_use_rd    = 1'b1;
                w_use_rs1   = 1'b1;
                w_is_mem    = 1'b1;
                w_raw_class = (w_funct3 == F3_WORD) ? CLS_LW : CLS_NONE;
            end
            OP_STORE: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_is_mem    = 1'b1;
                w_raw_class = (w_funct3 == F3_WORD) ? CLS_SW : CLS_NONE;
            end
            OP_NOP:  w_raw_class = CLS_NOP;
            default: w_raw_class = CLS_NONE;
        endcase

        // Offsets are kept small and based on one register so QED dups stay aligned.
        w_fmt_ok = (!w_use_rd  || reg_ok(w_rd))  &&
                   (!w_use_rs1 || reg_ok(w_rs1)) &&
                   (!w_use_rs2 || reg_ok(w_rs2)) &&
                   (!w_is_mem  || ((instruction[31:30] == 2'b00) && (w_rs1 == MEM_BASE)));
        inst_class = w_fmt_ok ? w_raw_class : CLS_NONE;
    end

endmodule

// File: rtl/qed_inst_stream_constraint.sv
// Stateful QED instruction-stream constraint: warm-up/run/drain phase FSM,
// NOP-run bound and a sticky first-violation latch around the shared decoder.
module qed_inst_stream_constraint
    import qed_inst_pkg::*;
#(
    parameter int REG_LIMIT    = 16,
    parameter int ENABLE_MUL   = 1,
    parameter int ENABLE_MEM   = 1,
    parameter int MEM_BASE_REG = 0,
    parameter int MAX_NOP_RUN  = 4,
    parameter int WARMUP_INSTS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        inst_valid,
    input  logic        drain_req,
    output logic        allowed,
    output logic [2:0]  inst_class,
    output logic [1:0]  phase,
    output logic [7:0]  nop_run,
    output logic        violation,
    output logic [31:0] viol_instr
);

    localparam logic [15:0] WARM_TGT = 16'(WARMUP_INSTS);
    localparam logic [7:0]  NOP_MAX  = 8'(MAX_NOP_RUN);
    localparam phase_e      PH_RESET = (WARMUP_INSTS == 0) ? PH_RUN : PH_WARMUP;

    phase_e      r_phase;
    logic [15:0] r_warm_cnt;
    logic [7:0]  r_nop_run;
    logic        r_violation;
    logic [31:0] r_viol_instr;

    logic [2:0]  w_class;
    logic        w_is_nop;
    logic        w_phase_ok;
    logic        w_nop_ok;
    logic        w_allowed;
    logic        w_warm_done;

    qed_inst_decode #(
        .REG_LIMIT    (REG_LIMIT),
        .ENABLE_MUL   (ENABLE_MUL),
        .MEM_BASE_REG (MEM_BASE_REG)
    ) u_decode (
        .instruction (instruction),
        .inst_class  (w_class)
    );

    // Legality of the current word given the phase and the running NOP count.
    always_comb begin
        w_is_nop = (w_class == CLS_NOP);
        w_nop_ok = !w_is_nop || (r_nop_run < NOP_MAX);
        case (r_phase)
            PH_WARMUP: w_phase_ok = is_alu_class(w_class) || w_is_nop;
            PH_RUN:    w_phase_ok = is_alu_class(w_class) || w_is_nop ||
                                    (is_mem_class(w_class) && (ENABLE_MEM != 0));
            PH_DRAIN:  w_phase_ok = w_is_nop;
            default:   w_phase_ok = 1'b0;
        endcase
        w_allowed   = (w_class != CLS_NONE) && w_phase_ok && w_nop_ok;
        w_warm_done = inst_valid && w_allowed && (r_phase == PH_WARMUP) && !w_is_nop &&
                      ((r_warm_cnt + 16'd1) == WARM_TGT);
    end

    // Phase FSM, warm-up and NOP counters, first-violation capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= PH_RESET;
            r_warm_cnt   <= 16'd0;
            r_nop_run    <= 8'd0;
            r_violation  <= 1'b0;
            r_viol_instr <= 32'd0;
        end else begin
            if (inst_valid) begin
                if (w_allowed) begin
                    if (w_is_nop) begin
                        r_nop_run <= (r_nop_run == 8'hFF) ? 8'hFF : (r_nop_run + 8'd1);
                    end else begin
                        r_nop_run <= 8'd0;
                    end
                    if ((r_phase == PH_WARMUP) && !w_is_nop) begin
                        r_warm_cnt <= r_warm_cnt + 16'd1;
                    end
                end else begin
                    r_violation <= 1'b1;
                    if (!r_violation) begin
                        r_viol_instr <= instruction;
                    end
                end
            end
            // Drain requests win over warm-up completion and need no valid instruction.
            case (r_phase)
                PH_WARMUP: begin
                    if (drain_req) begin
                        r_phase <= PH_DRAIN;
                    end else if (w_warm_done) begin
                        r_phase <= PH_RUN;
                    end
                end
                PH_RUN: begin
                    if (drain_req) begin
                        r_phase <= PH_DRAIN;
                    end
                end
                PH_DRAIN: r_phase <= PH_DRAIN;
                default:  r_phase <= PH_DRAIN;
            endcase
        end
    end

    assign allowed    = w_allowed;
    assign inst_class = w_class;
    assign phase      = r_phase;
    assign nop_run    = r_nop_run;
    assign violation  = r_violation;
    assign viol_instr = r_viol_instr;

`ifdef FORMAL
    assume property (@(posedge clk) disable iff (!rst_n) inst_valid |-> allowed);
`endif

endmodule

// File: tb/tb_qed_inst_stream_constraint.sv
// Three differently parameterised constraint instances share one stimulus
// stream; each is compared every cycle against a rule-level reference model.
module tb_qed_inst_stream_constraint;

    localparam int P_RL[3] = '{16, 32, 8};
    localparam int P_MUL[3] = '{1, 0, 1};
    localparam int P_MEM[3] = '{1, 1, 0};
    localparam int P_MB[3] = '{0, 3, 0};
    localparam int P_MN[3] = '{4, 2, 255};
    localparam int P_WI[3] = '{8, 0, 3};

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        drain_req;

    logic        al[3];
    logic [2:0]  cl[3];
    logic [1:0]  ph[3];
    logic [7:0]  nr[3];
    logic        vi[3];
    logic [31:0] vw[3];

    int          m_phase[3];
    int          m_warm[3];
    int          m_nop[3];
    bit          m_viol[3];
    logic [31:0] m_vinstr[3];

    int n_chk = 0;
    int n_bad = 0;

    qed_inst_stream_constraint u_dut0 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .inst_valid(inst_valid),
        .drain_req(drain_req), .allowed(al[0]), .inst_class(cl[0]), .phase(ph[0]),
        .nop_run(nr[0]), .violation(vi[0]), .viol_instr(vw[0]));

    qed_inst_stream_constraint #(
        .REG_LIMIT(32), .ENABLE_MUL(0), .ENABLE_MEM(1), .MEM_BASE_REG(3),
        .MAX_NOP_RUN(2), .WARMUP_INSTS(0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .inst_valid(inst_valid),
        .drain_req(drain_req), .allowed(al[1]), .inst_class(cl[1]), .phase(ph[1]),
        .nop_run(nr[1]), .violation(vi[1]), .viol_instr(vw[1]));

    qed_inst_stream_constraint #(
        .REG_LIMIT(8), .ENABLE_MUL(1), .ENABLE_MEM(0), .MEM_BASE_REG(0),
        .MAX_NOP_RUN(255), .WARMUP_INSTS(3)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .inst_valid(inst_valid),
        .drain_req(drain_req), .allowed(al[2]), .inst_class(cl[2]), .phase(ph[2]),
        .nop_run(nr[2]), .violation(vi[2]), .viol_instr(vw[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Class by the instruction-set rules: 0 NONE, 1 I, 2 R, 3 LW, 4 SW, 5 NOP.
    function automatic int mclass(input logic [31:0] w, input int k);
        logic [6:0] op  = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        int rd  = int'(w[11:7]);
        int rs1 = int'(w[19:15]);
        int rs2 = int'(w[24:20]);
        int lim = P_RL[k];
        int c = 0;
        bit ok = 1'b1;
        bit legal;
        if (op == 7'h13) begin
            legal = !((f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'h20));
            c  = legal ? 1 : 0;
            ok = (rd < lim) && (rs1 < lim);
        end else if (op == 7'h33) begin
            legal = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                    (f7 == 7'd1 && P_MUL[k] != 0 && f3 < 3'd4);
            c  = legal ? 2 : 0;
            ok = (rd < lim) && (rs1 < lim) && (rs2 < lim);
        end else if (op == 7'h03 && f3 == 3'd2) begin
            c  = 3;
            ok = (rd < lim) && (rs1 < lim) && (w[31:30] == 2'd0) && (rs1 == P_MB[k]);
        end else if (op == 7'h23 && f3 == 3'd2) begin
            c  = 4;
            ok = (rs1 < lim) && (rs2 < lim) && (w[31:30] == 2'd0) && (rs1 == P_MB[k]);
        end else if (op == 7'h7f) begin
            c = 5;
        end
        return ok ? c : 0;
    endfunction

    function automatic bit mallow(input int k, input int c);
        if (c == 0) return 1'b0;
        if (c == 5 && m_nop[k] >= P_MN[k]) return 1'b0;
        case (m_phase[k])
            0:       return (c == 1 || c == 2 || c == 5);
            1:       return (c == 1 || c == 2 || c == 5) || ((c == 3 || c == 4) && P_MEM[k] != 0);
            2:       return (c == 5);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k]  = (P_WI[k] == 0) ? 1 : 0;
            m_warm[k]   = 0;
            m_nop[k]    = 0;
            m_viol[k]   = 1'b0;
            m_vinstr[k] = 32'd0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int c  = mclass(instruction, k);
            bit a  = mallow(k, c);
            int np = m_phase[k];
            if (inst_valid) begin
                if (a) begin
                    m_nop[k] = (c == 5) ? ((m_nop[k] == 255) ? 255 : m_nop[k] + 1) : 0;
                    if (m_phase[k] == 0 && c != 5) begin
                        m_warm[k]++;
                        if (m_warm[k] == P_WI[k]) np = 1;
                    end
                end else begin
                    if (!m_viol[k]) m_vinstr[k] = instruction;
                    m_viol[k] = 1'b1;
                end
            end
            if (drain_req && m_phase[k] != 2) np = 2;
            m_phase[k] = np;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int c = mclass(instruction, k);
            chk($sformatf("class%0d", k), 32'(cl[k]), 32'(c));
            chk($sformatf("allowed%0d", k), 32'(al[k]), 32'(mallow(k, c)));
            chk($sformatf("phase%0d", k), 32'(ph[k]), 32'(m_phase[k]));
            chk($sformatf("nop_run%0d", k), 32'(nr[k]), 32'(m_nop[k]));
            chk($sformatf("violation%0d", k), 32'(vi[k]), 32'(m_viol[k]));
            chk($sformatf("viol_instr%0d", k), vw[k], m_vinstr[k]);
        end
    endtask

    task automatic drive(input logic [31:0] w, input bit v, input bit dr);
        instruction = w;
        inst_valid  = v;
        drain_req   = dr;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step(input logic [31:0] w, input bit v, input bit dr);
        drive(w, v, dr);
        tick();
    endtask

    // Asserted between edges so the asynchronous clear is seen before any clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [6:0] rnd_f7();
        case ($urandom_range(0, 3))
            0:       return 7'h00;
            1:       return 7'h20;
            2:       return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [1:0] top = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
        logic [4:0] mb  = ($urandom_range(0, 1) == 0) ? 5'd0 : (($urandom_range(0, 1) == 0) ? 5'd3 : rnd_reg());
        case ($urandom_range(0, 9))
            0, 1:    return {rnd_f7(), 5'($urandom), rnd_reg(), 3'($urandom), rnd_reg(), 7'h13};
            2, 3:    return {rnd_f7(), rnd_reg(), rnd_reg(), 3'($urandom), rnd_reg(), 7'h33};
            4:       return {top, 10'($urandom), mb, 3'd2, rnd_reg(), 7'h03};
            5:       return {top, 5'($urandom), rnd_reg(), mb, 3'd2, 5'($urandom), 7'h23};
            6, 7:    return {25'($urandom), 7'h7f};
            8:       return $urandom;
            default: return {12'($urandom_range(0, 63)), rnd_reg(), 3'd0, rnd_reg(), 7'h13};
        endcase
    endfunction

    initial begin
        rst_n       = 1'b0;
        instruction = 32'd0;
        inst_valid  = 1'b0;
        drain_req   = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Warm-up completes on the 8th accepted ADDI.
        for (int i = 0; i < 8; i++) begin
            drive(32'h00510093, 1'b1, 1'b0);
            chk("t1_allowed", 32'(al[0]), 32'd1);
            chk("t1_phase_warm", 32'(ph[0]), 32'd0);
            tick();
        end
        chk("t1_phase_run", 32'(ph[0]), 32'd1);

        // NOP run bound, then a store clears the run.
        for (int i = 0; i < 4; i++) step(32'h0000007F, 1'b1, 1'b0);
        chk("t3_nop_run4", 32'(nr[0]), 32'd4);
        drive(32'h0000007F, 1'b1, 1'b0);
        chk("t3_nop5_blocked", 32'(al[0]), 32'd0);
        tick();
        drive(32'h00102023, 1'b1, 1'b0);
        chk("t3_sw_allowed", 32'(al[0]), 32'd1);
        tick();
        chk("t3_nop_cleared", 32'(nr[0]), 32'd0);

        // Register limit and MUL gating across instances.
        drive(32'h00208A33, 1'b1, 1'b0);
        chk("t4_class_rl16", 32'(cl[0]), 32'd0);
        chk("t4_allowed_rl16", 32'(al[0]), 32'd0);
        chk("t4_allowed_rl32", 32'(al[1]), 32'd1);
        tick();
        drive(32'h023100B3, 1'b1, 1'b0);
        chk("t5_mul_off", 32'(al[1]), 32'd0);
        chk("t5_mul_class", 32'(cl[0]), 32'd2);
        chk("t5_mul_on", 32'(al[0]), 32'd1);
        tick();

        // Memory access during warm-up is a violation that leaves phase alone.
        do_reset();
        drive(32'h00002083, 1'b1, 1'b0);
        chk("t2_lw_warm", 32'(al[0]), 32'd0);
        tick();
        chk("t2_violation", 32'(vi[0]), 32'd1);
        chk("t2_viol_instr", vw[0], 32'h00002083);
        chk("t2_phase", 32'(ph[0]), 32'd0);

        // Drain entry without a valid instruction, then async reset mid-run.
        do_reset();
        for (int i = 0; i < 8; i++) step(32'h00510093, 1'b1, 1'b0);
        drive(32'h00510093, 1'b0, 1'b1);
        tick();
        chk("t6_drain", 32'(ph[0]), 32'd2);
        drive(32'h00510093, 1'b1, 1'b0);
        chk("t6_addi_drain", 32'(al[0]), 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_phase", 32'(ph[0]), 32'd0);
        chk("t6_rst_viol", 32'(vi[0]), 32'd0);
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step(rnd_instr(), $urandom_range(0, 4) != 0, $urandom_range(0, 199) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
